// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the IF/ID pipeline record used by the fetch stage.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Fetch-stage bus: control from hazard/ID logic, imem port, IF/ID view and perf counters.
interface if_id_fetch_stage_if;
    logic        start_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_valid_o;
    logic [4:0]  id_rs1_o;
    logic [4:0]  id_rs2_o;
    logic [6:0]  id_opcode_o;
    logic [31:0] perf_stall_o;
    logic [31:0] perf_flush_o;
    logic [31:0] perf_fetch_o;

    modport master (
        output start_i, stall_i, flush_i, branch_target_i, imem_data_i,
        input  imem_addr_o, id_pc_o, id_instr_o, id_valid_o,
        input  id_rs1_o, id_rs2_o, id_opcode_o,
        input  perf_stall_o, perf_flush_o, perf_fetch_o
    );

    modport slave (
        input  start_i, stall_i, flush_i, branch_target_i, imem_data_i,
        output imem_addr_o, id_pc_o, id_instr_o, id_valid_o,
        output id_rs1_o, id_rs2_o, id_opcode_o,
        output perf_stall_o, perf_flush_o, perf_fetch_o
    );
endinterface

// File: rtl/if_id_fetch_stage_if_id_reg.sv
// IF/ID pipeline latch: bubble beats load, otherwise holds.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bubble_i,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output if_id_t      q_o
);

    if_id_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (bubble_i) begin
            q_d.pc    = 32'h0;
            q_d.instr = BUBBLE_INSTR;
            q_d.valid = 1'b0;
        end else if (load_i) begin
            q_d.pc    = pc_i;
            q_d.instr = instr_i;
            q_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q.pc    <= 32'h0;
            q_q.instr <= BUBBLE_INSTR;
            q_q.valid <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// IF stage: PC register, next-PC mux and IF/ID register; priority flush > !start > stall > advance.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush/fetch counters; otherwise perf outputs are 0.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    if_id_fetch_stage_if.slave    bus
);
    import riscv_pkg::*;

    logic [31:0] pc_q, pc_d;
    logic        advance, bubble;
    if_id_t      id_q;

    always_comb begin
        advance = bus.start_i && !bus.stall_i && !bus.flush_i;
        bubble  = bus.flush_i || !bus.start_i;
        pc_d    = pc_q;
        if (bus.flush_i) begin
            pc_d = bus.branch_target_i & ~32'h3;
        end else if (advance) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bubble_i (bubble),
        .load_i   (advance),
        .pc_i     (pc_q),
        .instr_i  (bus.imem_data_i),
        .q_o      (id_q)
    );

    assign bus.imem_addr_o = pc_q;
    assign bus.id_pc_o     = id_q.pc;
    assign bus.id_instr_o  = id_q.instr;
    assign bus.id_valid_o  = id_q.valid;
    // Bubbles hold NOP_INSTR, whose register fields are x0, so hazard logic never stalls on them.
    assign bus.id_rs1_o    = id_q.instr[19:15];
    assign bus.id_rs2_o    = id_q.instr[24:20];
    assign bus.id_opcode_o = id_q.instr[6:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_fetch_q, perf_fetch_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        perf_fetch_d = perf_fetch_q;
        if (bus.stall_i && !bus.flush_i && bus.start_i) perf_stall_d = sat_inc(perf_stall_q);
        if (bus.flush_i)                                perf_flush_d = sat_inc(perf_flush_q);
        if (advance)                                    perf_fetch_d = sat_inc(perf_fetch_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
            perf_fetch_q <= 32'h0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_fetch_q <= perf_fetch_d;
        end
    end

    assign bus.perf_stall_o = perf_stall_q;
    assign bus.perf_flush_o = perf_flush_q;
    assign bus.perf_fetch_o = perf_fetch_q;
`else
    assign bus.perf_stall_o = 32'h0;
    assign bus.perf_flush_o = 32'h0;
    assign bus.perf_fetch_o = 32'h0;
`endif

endmodule
